switch_operand_loader: RTL and testbench



---
 rtl/switch_pkg.sv | 19 +
 rtl/pair_fifo.sv | 63 ++++++
 rtl/switch_operand_loader.sv | 94 +++++++++
 tb/tb_switch_operand_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the sign-select switch operand path.
package switch_pkg;

    localparam int WORD_W   = 6;
    localparam int SIGN_BIT = WORD_W - 1;

    typedef logic [WORD_W-1:0] operand_t;

    typedef struct packed {
        operand_t x;
        operand_t y;
    } pair_t;

    typedef enum logic {
        S_X,
        S_Y
    } loader_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Show-ahead FIFO of operand pairs with synchronous flush and occupancy level.
module pair_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  pair_t                    wdata_i,
    output pair_t                    rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    pair_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    // Full/empty come from the registered count so the write side never sees the read side combinationally.
    assign full_o  = (cnt_q == LVL_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointer and occupancy bookkeeping; flush empties the FIFO ahead of any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LVL_W'(1);
                2'b01:   cnt_q <= cnt_q - LVL_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Pair storage write port.
    // NOTE: storage has no reset; entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/switch_operand_loader.sv
// Pairs an input word stream into (x, y) operands and presents them to the switch.
module switch_operand_loader
    import switch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WORD_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      x,
    output logic [WORD_W-1:0]      y,
    output logic                   sign_match,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       pair_count
);

    loader_state_t    state_q, state_d;
    operand_t         x_hold_q, x_hold_d;
    logic [CNT_W-1:0] pair_count_q;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    pair_t            head;

    pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ('{x: x_hold_q, y: in_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // State, held first operand and delivered-pair counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_X;
            x_hold_q     <= '0;
            pair_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            x_hold_q <= x_hold_d;
            if (pop) pair_count_q <= pair_count_q + CNT_W'(1);
        end
    end

    // Pairing FSM: first accepted word is held as x, second is pushed with it as y.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        x_hold_d = x_hold_q;
        in_ready = 1'b1;
        push     = 1'b0;
        case (state_q)
            S_X: begin
                if (in_valid) begin
                    x_hold_d = in_data;
                    state_d  = S_Y;
                end
            end
            S_Y: begin
                in_ready = ~fifo_full;
                if (in_valid && !fifo_full) begin
                    push    = 1'b1;
                    state_d = S_X;
                end
            end
            default: state_d = S_X;
        endcase
        if (flush) begin
            state_d  = S_X;
            x_hold_d = '0;
            push     = 1'b0;
        end
    end

    assign pop        = ~fifo_empty & out_ready & ~flush;
    assign out_valid  = ~fifo_empty;
    assign x          = fifo_empty ? '0 : head.x;
    assign y          = fifo_empty ? '0 : head.y;
    assign sign_match = out_valid & (x[SIGN_BIT] == y[SIGN_BIT]);
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_switch_operand_loader.sv
// Self-checking bench for switch_operand_loader with a pair scoreboard.
module tb_switch_operand_loader;
    import switch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [5:0]             in_data = '0;
    logic                   in_ready;
    logic                   flush = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [5:0]             x, y;
    logic                   sign_match;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       pair_count;

    int total = 0;
    int bad   = 0;

    // Scoreboard model of the input pairing and output queue.
    pair_t            sb[$];
    logic             m_have_x = 1'b0;
    logic [5:0]       m_x = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    switch_operand_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .x          (x),
        .y          (y),
        .sign_match (sign_match),
        .level      (level),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    // Per-cycle monitor: sample at the falling edge, compare against the model, then advance it.
    always @(negedge clk) begin
        pair_t exp;
        logic  exp_ready;
        if (!rst_n) begin
            sb.delete();
            m_have_x = 1'b0;
            m_x      = '0;
            m_cnt    = '0;
        end else begin
            exp_ready = m_have_x ? (sb.size() < DEPTH) : 1'b1;
            total++;
            if (in_ready !== exp_ready) begin
                bad++; $display("FAIL mon_in_ready got=%b want=%b t=%0t", in_ready, exp_ready, $time);
            end
            total++;
            if (level !== sb.size()) begin
                bad++; $display("FAIL mon_level got=%0d want=%0d t=%0t", level, sb.size(), $time);
            end
            total++;
            if (out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL mon_out_valid got=%b want=%b t=%0t", out_valid, sb.size() != 0, $time);
            end
            total++;
            if (pair_count !== m_cnt) begin
                bad++; $display("FAIL mon_pair_count got=%0d want=%0d t=%0t", pair_count, m_cnt, $time);
            end
            if (sb.size() == 0) begin
                total++;
                if (x !== 6'd0 || y !== 6'd0 || sign_match !== 1'b0) begin
                    bad++; $display("FAIL mon_empty_mask got x=%b y=%b sm=%b want zeros t=%0t", x, y, sign_match, $time);
                end
            end
            if (flush) begin
                sb.delete();
                m_have_x = 1'b0;
            end else begin
                if (sb.size() != 0 && out_ready) begin
                    exp = sb.pop_front();
                    total++;
                    if (x !== exp.x || y !== exp.y || sign_match !== (exp.x[5] == exp.y[5])) begin
                        bad++;
                        $display("FAIL mon_pop_pair got x=%b y=%b sm=%b want x=%b y=%b sm=%b t=%0t",
                                 x, y, sign_match, exp.x, exp.y, exp.x[5] == exp.y[5], $time);
                    end
                    m_cnt = m_cnt + 1'b1;
                end
                if (in_valid && exp_ready) begin
                    if (!m_have_x) begin
                        m_x      = in_data;
                        m_have_x = 1'b1;
                    end else begin
                        sb.push_back('{x: m_x, y: in_data});
                        m_have_x = 1'b0;
                    end
                end
            end
        end
    end

    // Offer one word and hold it until accepted; called and returns at posedge+1.
    task automatic send_word(input logic [5:0] d);
        int   n  = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout got=not_accepted want=accepted word=%b", d);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        total++;
        if (out_valid !== 1'b0 || x !== 6'd0 || y !== 6'd0 || sign_match !== 1'b0 ||
            level !== 0 || pair_count !== 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got ov=%b x=%b y=%b sm=%b lvl=%0d cnt=%0d rdy=%b want 0/0/0/0/0/0/1",
                     out_valid, x, y, sign_match, level, pair_count, in_ready);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send_word(6'b101011);
        send_word(6'b001100);
        total++;
        if (out_valid !== 1'b1 || x !== 6'b101011 || y !== 6'b001100 || sign_match !== 1'b0) begin
            bad++;
            $display("FAIL basic_pair got ov=%b x=%b y=%b sm=%b want ov=1 x=101011 y=001100 sm=0",
                     out_valid, x, y, sign_match);
        end
        step(1);
        total++;
        if (pair_count !== 8'd1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_count got cnt=%0d ov=%b want cnt=1 ov=0", pair_count, out_valid);
        end
    endtask

    task automatic test_sign_match;
        out_ready = 1'b1;
        send_word(6'b011101);
        send_word(6'b011001);
        total++;
        if (sign_match !== 1'b1 || x !== 6'b011101) begin
            bad++; $display("FAIL sign_pos got sm=%b x=%b want sm=1 x=011101", sign_match, x);
        end
        step(1);
        send_word(6'b100000);
        send_word(6'b100000);
        total++;
        if (sign_match !== 1'b1 || y !== 6'b100000) begin
            bad++; $display("FAIL sign_neg got sm=%b y=%b want sm=1 y=100000", sign_match, y);
        end
        step(1);
    endtask

    task automatic test_full_stall;
        logic [5:0] w10;
        out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH + 1; i++) send_word(6'($urandom_range(0, 63)));
        total++;
        if (level !== DEPTH || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_level got lvl=%0d rdy=%b want lvl=%0d rdy=0", level, in_ready, DEPTH);
        end
        w10      = 6'($urandom_range(0, 63));
        in_valid = 1'b1;
        in_data  = w10;
        step(2);
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready_same_cycle got=%b want=0", in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL full_ready_after_pop got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        step(DEPTH + 3);
        total++;
        if (level !== 0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL full_drain got lvl=%0d ov=%b want lvl=0 ov=0", level, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] w[6];
        for (int i = 0; i < 6; i++) w[i] = 6'($urandom_range(0, 63));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(w[i]);
        total++;
        if (level !== 2) begin
            bad++; $display("FAIL b2b_pre_level got=%0d want=2", level);
        end
        in_valid  = 1'b1;
        in_data   = w[5];
        out_ready = 1'b1;
        step(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (level !== 2 || x !== w[2] || y !== w[3]) begin
            bad++;
            $display("FAIL b2b_push_pop got lvl=%0d x=%b y=%b want lvl=2 x=%b y=%b", level, x, y, w[2], w[3]);
        end
        out_ready = 1'b1;
        step(3);
        total++;
        if (level !== 0) begin
            bad++; $display("FAIL b2b_drain got=%0d want=0", level);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        send_word(6'b000001);
        send_word(6'b000010);
        send_word(6'b010101);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'b000111;
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (level !== 0 || out_valid !== 1'b0 || x !== 6'd0) begin
            bad++; $display("FAIL flush_clear got lvl=%0d ov=%b x=%b want 0/0/0", level, out_valid, x);
        end
        send_word(6'b111111);
        send_word(6'b011011);
        total++;
        if (level !== 1 || x !== 6'b111111 || y !== 6'b011011 || sign_match !== 1'b0) begin
            bad++;
            $display("FAIL flush_repair got lvl=%0d x=%b y=%b sm=%b want lvl=1 x=111111 y=011011 sm=0",
                     level, x, y, sign_match);
        end
        out_ready = 1'b1;
        step(2);
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_word(6'($urandom_range(0, 63)));
        step(1);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_word(6'($urandom_range(0, 63)));
        total++;
        if (level !== 3 || pair_count !== 8'd5) begin
            bad++; $display("FAIL mid_pre got lvl=%0d cnt=%0d want lvl=3 cnt=5", level, pair_count);
        end
        in_valid = 1'b1;
        in_data  = 6'b110011;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || x !== 6'd0 || y !== 6'd0 || sign_match !== 1'b0 ||
            level !== 0 || pair_count !== 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_async_reset got ov=%b x=%b y=%b sm=%b lvl=%0d cnt=%0d rdy=%b want 0/0/0/0/0/0/1",
                     out_valid, x, y, sign_match, level, pair_count, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_count_wrap;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * 256; i++) send_word(6'($urandom_range(0, 63)));
        step(3);
        total++;
        if (pair_count !== 8'd0 || level !== 0) begin
            bad++; $display("FAIL count_wrap got cnt=%0d lvl=%0d want cnt=0 lvl=0", pair_count, level);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_sign_match();
        test_full_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_count_wrap();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
